// File: rtl/corral_player.sv
// corral_player: player-side initiator for the Corral enter/move/ready interface.
// Debounces three buttons, keeps a wrapping 3-bit move, and drives one 7-segment digit.
`default_nettype none

module corral_player #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_go,
    input  logic       ready,
    input  logic       gameover,
    input  logic       lostwon,
    output logic [2:0] move,
    output logic       enter,
    output logic [6:0] seg,
    output logic       busy
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    localparam logic [6:0] SEG_WON  = 7'b0111110;
    localparam logic [6:0] SEG_LOST = 7'b0111000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_go, btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic        sync1_q;
            logic        sync2_q;
            logic        level_q;
            logic        press_q;
            logic [15:0] cnt_q;

            // The counter only runs while the synchronized sample disagrees with the accepted level.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    press_q <= 1'b0;
                    cnt_q   <= 16'd0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    press_q <= 1'b0;
                    if (sync2_q != level_q) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= 16'd0;
                            level_q <= sync2_q;
                            press_q <= sync2_q;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end else begin
                        cnt_q <= 16'd0;
                    end
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    logic press_up;
    logic press_down;
    logic press_go;

    assign press_up   = press[0];
    assign press_down = press[1];
    assign press_go   = press[2];

    function automatic logic [6:0] digit_seg(input logic [2:0] d);
        logic [6:0] s;
        s = 7'b0111111;
        case (d)
            3'd0: s = 7'b0111111;
            3'd1: s = 7'b0000110;
            3'd2: s = 7'b1011011;
            3'd3: s = 7'b1001111;
            3'd4: s = 7'b1100110;
            3'd5: s = 7'b1101101;
            3'd6: s = 7'b1111101;
            3'd7: s = 7'b0000111;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] move_q, move_d;
    logic       enter_q, enter_d;
    logic       busy_q, busy_d;
    logic [6:0] seg_q, seg_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            move_q  <= 3'd0;
            enter_q <= 1'b0;
            busy_q  <= 1'b0;
            seg_q   <= 7'b0111111;
        end else begin
            state_q <= state_d;
            move_q  <= move_d;
            enter_q <= enter_d;
            busy_q  <= busy_d;
            seg_q   <= seg_d;
        end
    end

    // gameover wins over every other condition in every state.
    always_comb begin
        state_d = state_q;
        move_d  = move_q;
        case (state_q)
            ST_IDLE: begin
                if (gameover) begin
                    state_d = ST_DONE;
                end else begin
                    if (press_up && !press_down) begin
                        move_d = move_q + 3'd1;
                    end else if (press_down && !press_up) begin
                        move_d = move_q - 3'd1;
                    end
                    if (press_go && ready) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (gameover) begin
                    state_d = ST_DONE;
                end else if (!ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (gameover) begin
                    state_d = ST_DONE;
                end else if (ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!gameover) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        enter_d = (state_d == ST_ISSUE);
        busy_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        if (state_d == ST_DONE) begin
            seg_d = lostwon ? SEG_WON : SEG_LOST;
        end else begin
            seg_d = digit_seg(move_d);
        end
    end

    assign move  = move_q;
    assign enter = enter_q;
    assign busy  = busy_q;
    assign seg   = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_corral_player.sv
// Scoreboard bench for corral_player: expected move values are queued as presses
// are driven and consumed whenever the DUT's move output changes.
`default_nettype none

module tb_corral_player;

    logic       clock;
    logic       reset_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_go;
    logic       ready;
    logic       gameover;
    logic       lostwon;
    logic [2:0] move;
    logic       enter;
    logic [6:0] seg;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_q[$];
    logic [2:0] prev_move = 3'd0;
    logic       mon_en    = 1'b0;

    corral_player #(.DEBOUNCE_CYCLES(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_go   (btn_go),
        .ready    (ready),
        .gameover (gameover),
        .lostwon  (lostwon),
        .move     (move),
        .enter    (enter),
        .seg      (seg),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive a clean press (hold long enough to debounce) followed by a clean release.
    task automatic press(input logic up, input logic down, input logic go);
        btn_up   = up;
        btn_down = down;
        btn_go   = go;
        tick(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_go   = 1'b0;
        tick(8);
    endtask

    always @(posedge clock) begin
        #2;
        if (mon_en && (move !== prev_move)) begin
            if (exp_q.size() == 0) begin
                check("move_unexpected", 32'(move), 32'(prev_move));
            end else begin
                check("move_sb", 32'(move), 32'(exp_q.pop_front()));
            end
        end
        prev_move = move;
    end

    initial begin
        logic       saw_enter;
        logic [2:0] m;

        reset_n  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_go   = 1'b0;
        ready    = 1'b0;
        gameover = 1'b0;
        lostwon  = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check("rst_move",  32'(move),  32'd0);
        check("rst_enter", 32'(enter), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_seg",   32'(seg),   32'(7'b0111111));
        mon_en = 1'b1;

        // Three-cycle glitch never reaches the debounce threshold.
        btn_up = 1'b1;
        tick(3);
        btn_up = 1'b0;
        tick(10);
        check("glitch_move", 32'(move), 32'd0);

        // Held press: effect lands 2 sync + 4 debounce + 1 cycles after the edge.
        exp_q.push_back(3'd1);
        btn_up = 1'b1;
        tick(6);
        check("dbnc_pre", 32'(move), 32'd0);
        tick(1);
        check("dbnc_edge", 32'(move), 32'd1);
        tick(3);
        btn_up = 1'b0;
        tick(8);
        check("dbnc_single", 32'(move), 32'd1);

        m = 3'd1;
        for (int i = 0; i < 7; i++) begin
            m = m + 3'd1;
            exp_q.push_back(m);
            press(1'b1, 1'b0, 1'b0);
        end
        check("wrap_up_seg", 32'(seg), 32'(7'b0111111));

        exp_q.push_back(3'd7);
        press(1'b0, 1'b1, 1'b0);
        check("wrap_dn_seg", 32'(seg), 32'(7'b0000111));

        press(1'b1, 1'b1, 1'b0);
        check("updown_move", 32'(move), 32'd7);

        exp_q.push_back(3'd6);
        press(1'b0, 1'b1, 1'b0);
        exp_q.push_back(3'd5);
        press(1'b0, 1'b1, 1'b0);
        check("move5_seg", 32'(seg), 32'(7'b1101101));

        // Handshake with ready held high, then dropped.
        ready  = 1'b1;
        btn_go = 1'b1;
        tick(6);
        check("go_pre_enter", 32'(enter), 32'd0);
        tick(1);
        check("go_enter", 32'(enter), 32'd1);
        check("go_move",  32'(move),  32'd5);
        check("go_busy",  32'(busy),  32'd1);
        btn_go = 1'b0;
        tick(5);
        check("hold_enter", 32'(enter), 32'd1);
        ready = 1'b0;
        tick(1);
        check("ack_enter", 32'(enter), 32'd0);
        check("ack_busy",  32'(busy),  32'd1);
        press(1'b1, 1'b0, 1'b0);
        check("wait_busy", 32'(busy), 32'd1);
        ready = 1'b1;
        tick(1);
        check("ret_busy", 32'(busy), 32'd0);
        check("ret_move", 32'(move), 32'd5);

        // Go press with ready low is discarded.
        ready     = 1'b0;
        saw_enter = 1'b0;
        btn_go    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) btn_go = 1'b0;
            tick(1);
            saw_enter = saw_enter | enter;
        end
        tick(4);
        saw_enter = saw_enter | enter;
        check("nogo_enter", 32'(saw_enter), 32'd0);
        check("nogo_busy",  32'(busy),      32'd0);

        // Game ends during ISSUE.
        ready  = 1'b1;
        btn_go = 1'b1;
        tick(7);
        check("go2_enter", 32'(enter), 32'd1);
        btn_go   = 1'b0;
        gameover = 1'b1;
        lostwon  = 1'b1;
        tick(1);
        check("done_enter", 32'(enter), 32'd0);
        check("done_busy",  32'(busy),  32'd0);
        check("done_won",   32'(seg),   32'(7'b0111110));
        lostwon = 1'b0;
        tick(1);
        check("done_lost", 32'(seg), 32'(7'b0111000));
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        check("done_ign_seg",   32'(seg),   32'(7'b0111000));
        check("done_ign_enter", 32'(enter), 32'd0);
        gameover = 1'b0;
        tick(1);
        check("restart_seg",  32'(seg),  32'(7'b1101101));
        check("restart_move", 32'(move), 32'd5);
        tick(2);

        // Asynchronous reset in the middle of ISSUE.
        btn_go = 1'b1;
        tick(7);
        check("go3_enter", 32'(enter), 32'd1);
        exp_q.push_back(3'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_enter", 32'(enter), 32'd0);
        check("arst_move",  32'(move),  32'd0);
        btn_go = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("arst_seg",  32'(seg),  32'(7'b0111111));
        check("arst_busy", 32'(busy), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
